// File: rtl/ud_cnt_mod_if.sv
// Control and status bundle of the up/down modulus counter.
// The step input exists only when UD_CNT_STEP_EN is defined.
interface ud_cnt_mod_if #(
    parameter int WIDTH = 8
);
    logic             ce;
    logic             ld;
    logic             ud;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] limit;
    logic             sat;
    logic             clr;
    logic [WIDTH-1:0] cmp_val;
    logic             clr_flag;
`ifdef UD_CNT_STEP_EN
    logic [WIDTH-1:0] step;
`endif
    logic [WIDTH-1:0] q;
    logic             ovf;
    logic             unf;
    logic             at_end;
    logic             match;
    logic             match_flag;

    // The counter has no handshake: every input is sampled on each rising clk,
    // and q/ovf/unf/match/match_flag are registered outputs that change one
    // cycle later. at_end is combinational from q, ud and limit.
    modport master (
        output ce, ld, ud, d, limit, sat, clr, cmp_val, clr_flag,
`ifdef UD_CNT_STEP_EN
        output step,
`endif
        input  q, ovf, unf, at_end, match, match_flag
    );

    modport slave (
        input  ce, ld, ud, d, limit, sat, clr, cmp_val, clr_flag,
`ifdef UD_CNT_STEP_EN
        input  step,
`endif
        output q, ovf, unf, at_end, match, match_flag
    );
endinterface

// File: rtl/ud_cnt_mod.sv
// Up/down counter with runtime modulus (0..limit), wrap/saturate, compare match.
// Optional UD_CNT_STEP_EN adds a step input; otherwise the count moves by 1.
module ud_cnt_mod #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    ud_cnt_mod_if.slave  bus
);
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic             ovf_r;
    logic             ovf_nxt;
    logic             unf_r;
    logic             unf_nxt;
    logic             match_r;
    logic             match_nxt;
    logic             flag_r;
    logic             flag_nxt;
    logic             event_nxt;

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] up_base;
    logic [WIDTH:0]   up_sum;

    // Effective step, clamped to the modulus range.
`ifdef UD_CNT_STEP_EN
    always_comb begin
        s = (bus.step > bus.limit) ? bus.limit : bus.step;
    end
`else
    always_comb begin
        s = {{(WIDTH-1){1'b0}}, 1'b1};
    end
`endif

    // A count above a lowered limit is treated as sitting at limit when counting up.
    always_comb begin
        up_base = (q_r > bus.limit) ? bus.limit : q_r;
        up_sum  = {1'b0, up_base} + {1'b0, s};
    end

    always_comb begin
        q_nxt     = q_r;
        ovf_nxt   = 1'b0;
        unf_nxt   = 1'b0;
        event_nxt = 1'b0;
        if (bus.clr) begin
            q_nxt     = '0;
            event_nxt = 1'b1;
        end else if (bus.ce) begin
            event_nxt = 1'b1;
            if (bus.ld) begin
                q_nxt = (bus.d > bus.limit) ? bus.limit : bus.d;
            end else if (s == '0) begin
                q_nxt = q_r;
            end else if (bus.ud) begin
                if (up_sum > {1'b0, bus.limit}) begin
                    if (bus.sat) begin
                        q_nxt = bus.limit;
                    end else begin
                        // True result lies in 0..limit, so modulo-2^WIDTH math is exact.
                        q_nxt   = up_base + s - bus.limit - WIDTH'(1);
                        ovf_nxt = 1'b1;
                    end
                end else begin
                    q_nxt = up_base + s;
                end
            end else begin
                if (q_r > bus.limit) begin
                    q_nxt = bus.limit;
                end else if (s > q_r) begin
                    if (bus.sat) begin
                        q_nxt = '0;
                    end else begin
                        q_nxt   = q_r + bus.limit + WIDTH'(1) - s;
                        unf_nxt = 1'b1;
                    end
                end else begin
                    q_nxt = q_r - s;
                end
            end
        end
    end

    always_comb begin
        match_nxt = event_nxt && (q_nxt == bus.cmp_val);
        flag_nxt  = match_nxt || (flag_r && !bus.clr_flag);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r     <= '0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
            match_r <= 1'b0;
            flag_r  <= 1'b0;
        end else begin
            q_r     <= q_nxt;
            ovf_r   <= ovf_nxt;
            unf_r   <= unf_nxt;
            match_r <= match_nxt;
            flag_r  <= flag_nxt;
        end
    end

    assign bus.q          = q_r;
    assign bus.ovf        = ovf_r;
    assign bus.unf        = unf_r;
    assign bus.match      = match_r;
    assign bus.match_flag = flag_r;
    assign bus.at_end     = (bus.ud && (q_r >= bus.limit)) || (!bus.ud && (q_r == '0));
endmodule

// File: tb/tb_ud_cnt_mod.sv
// Bench for ud_cnt_mod: directed scenarios plus random stimulus against a
// modular-arithmetic reference model.
module tb_ud_cnt_mod;
    localparam int W = 8;

    logic clk;
    logic rst_n;

    ud_cnt_mod_if #(.WIDTH(W)) bus ();

    ud_cnt_mod #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [W-1:0] exp_q[$];

    int mq;
    bit movf, munf, mm, mf;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: the counter lives on the ring 0..limit; wraps are mod (limit+1).
    task automatic model_edge();
        int lim, m, s, nq;
        bit ev;
        lim = int'(bus.limit);
        m   = lim + 1;
        if (!rst_n) begin
            mq = 0; movf = 0; munf = 0; mm = 0; mf = 0;
            return;
        end
        nq = mq; ev = 0; movf = 0; munf = 0;
`ifdef UD_CNT_STEP_EN
        s = (int'(bus.step) > lim) ? lim : int'(bus.step);
`else
        s = 1;
`endif
        if (bus.clr) begin
            nq = 0; ev = 1;
        end else if (bus.ce) begin
            ev = 1;
            if (bus.ld) begin
                nq = (int'(bus.d) > lim) ? lim : int'(bus.d);
            end else if (s == 0) begin
                nq = mq;
            end else if (bus.ud) begin
                int b;
                b = (mq > lim) ? lim : mq;
                if (b + s > lim) begin
                    if (bus.sat) nq = lim;
                    else begin nq = (b + s) % m; movf = 1; end
                end else nq = b + s;
            end else begin
                if (mq > lim) nq = lim;
                else if (s > mq) begin
                    if (bus.sat) nq = 0;
                    else begin nq = (mq - s + m) % m; munf = 1; end
                end else nq = mq - s;
            end
        end
        mq = nq;
        mm = ev && (nq == int'(bus.cmp_val));
        if (mm) mf = 1;
        else if (bus.clr_flag) mf = 0;
    endtask

    task automatic cyc();
        bit exp_end;
        @(posedge clk);
        model_edge();
        exp_q.push_back(W'(mq));
        @(negedge clk);
        chk("q", 32'(bus.q), 32'(exp_q.pop_front()));
        chk("ovf", 32'(bus.ovf), 32'(movf));
        chk("unf", 32'(bus.unf), 32'(munf));
        chk("match", 32'(bus.match), 32'(mm));
        chk("match_flag", 32'(bus.match_flag), 32'(mf));
        exp_end = (bus.ud && mq >= int'(bus.limit)) || (!bus.ud && mq == 0);
        chk("at_end", 32'(bus.at_end), 32'(exp_end));
    endtask

    task automatic idle();
        bus.ce = 0; bus.ld = 0; bus.clr = 0; bus.clr_flag = 0;
    endtask

    initial begin
        rst_n = 0;
        idle();
        bus.ud = 1; bus.d = '0; bus.limit = 8'd20; bus.sat = 0; bus.cmp_val = 8'd200;
`ifdef UD_CNT_STEP_EN
        bus.step = 8'd1;
`endif
        cyc(); cyc();
        chk("rst_q", 32'(bus.q), 0);
        chk("rst_flag", 32'(bus.match_flag), 0);
        rst_n = 1;

        // Reset mid-count, with clr and ld asserted during reset
        bus.ce = 1;
        repeat (5) cyc();
        chk("cnt5_q", 32'(bus.q), 5);
        rst_n = 0; bus.clr = 1; bus.ld = 1; bus.d = 8'd7;
        cyc();
        chk("rst_mid_q", 32'(bus.q), 0);
        chk("rst_mid_ovf", 32'(bus.ovf), 0);
        rst_n = 1; idle();

        // Wrap up at limit 9
        bus.limit = 8'd9; bus.ce = 1; bus.ud = 1;
        repeat (9) cyc();
        chk("wrap_q9", 32'(bus.q), 9);
        chk("wrap_at_end", 32'(bus.at_end), 1);
        cyc();
        chk("wrap_q0", 32'(bus.q), 0);
        chk("wrap_ovf", 32'(bus.ovf), 1);
        cyc();
        chk("wrap_ovf_drop", 32'(bus.ovf), 0);

        // Saturate down, then underflow with wrap
        bus.ld = 1; bus.d = 8'd2; bus.sat = 1;
        cyc();
        bus.ld = 0; bus.ud = 0;
        repeat (4) cyc();
        chk("satdn_q", 32'(bus.q), 0);
        chk("satdn_unf", 32'(bus.unf), 0);
        bus.sat = 0;
        cyc();
        chk("unf_q", 32'(bus.q), 9);
        chk("unf_pulse", 32'(bus.unf), 1);

        // Load clamp and lowered limit
        bus.limit = 8'd20; bus.ld = 1; bus.d = 8'd50; bus.ud = 1;
        cyc();
        chk("clamp_q", 32'(bus.q), 20);
        bus.ld = 0; bus.limit = 8'd10; bus.ud = 0;
        cyc();
        chk("lower_q", 32'(bus.q), 10);
        chk("lower_unf", 32'(bus.unf), 0);
        bus.ud = 1;
        cyc();
        chk("lower_wrap_q", 32'(bus.q), 0);
        chk("lower_wrap_ovf", 32'(bus.ovf), 1);

        // Compare match and sticky flag
        idle();
        bus.limit = 8'd9; bus.cmp_val = 8'd3; bus.clr = 1;
        cyc();
        bus.clr = 0; bus.ce = 1; bus.ud = 1;
        repeat (3) cyc();
        chk("match_pulse", 32'(bus.match), 1);
        chk("match_flag_set", 32'(bus.match_flag), 1);
        bus.ce = 0;
        cyc();
        chk("match_hold", 32'(bus.match), 0);
        bus.ce = 1; bus.ld = 1; bus.d = 8'd3; bus.clr_flag = 1;
        cyc();
        chk("match_vs_clr", 32'(bus.match_flag), 1);
        bus.ce = 0; bus.ld = 0;
        cyc();
        chk("flag_cleared", 32'(bus.match_flag), 0);
        idle();

`ifdef UD_CNT_STEP_EN
        bus.limit = 8'd9; bus.step = 8'd4; bus.sat = 0;
        bus.ce = 1; bus.ld = 1; bus.d = 8'd7;
        cyc();
        bus.ld = 0; bus.ud = 1;
        cyc();
        chk("step_up_q", 32'(bus.q), 1);
        chk("step_up_ovf", 32'(bus.ovf), 1);
        bus.ud = 0;
        cyc();
        chk("step_dn_q", 32'(bus.q), 7);
        chk("step_dn_unf", 32'(bus.unf), 1);
        bus.step = 8'd15; bus.clr = 1;
        cyc();
        bus.clr = 0; bus.ud = 1;
        cyc();
        chk("step_clamp_q", 32'(bus.q), 9);
        idle();
`endif

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            rst_n        = ($urandom_range(0, 99) >= 2);
            bus.ce       = ($urandom_range(0, 99) < 80);
            bus.ld       = ($urandom_range(0, 99) < 10);
            bus.clr      = ($urandom_range(0, 99) < 4);
            bus.clr_flag = ($urandom_range(0, 99) < 8);
            bus.ud       = ($urandom_range(0, 99) < 55);
            if ($urandom_range(0, 99) < 20) bus.sat = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 3) begin
                if ($urandom_range(0, 9) == 0) bus.limit = 8'd255;
                else bus.limit = 8'($urandom_range(0, 15));
                bus.cmp_val = 8'($urandom_range(0, int'(bus.limit)));
            end
            bus.d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'($urandom_range(0, 15));
`ifdef UD_CNT_STEP_EN
            if ($urandom_range(0, 99) < 10) bus.step = 8'($urandom_range(0, 20));
`endif
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
